// File: rtl/qr_givens_engine.sv
// -----------------------------------------------------------------------------
// qr_givens_engine
//
// In-place Givens QR triangularisation of a ROWS x COLS signed matrix held in
// an external dual-port RAM (column-major: address = col*ROWS + row). A single
// iterative CORDIC datapath performs one micro-rotation per clock. It works in
// vectoring mode to zero A[i][j] against A[i-1][j]. It then works in rotation
// mode to apply the same angle to the rest of rows i-1 and i.
//
// Ports:
//   clk          in   clock
//   reset        in   asynchronous, active-low reset
//   start        in   begin a decomposition (sampled only in IDLE)
//   busy         out  high from the cycle after an accepted start to last WR_Y
//   done         out  one-cycle pulse after the last write
//   mem_rd       out  RAM read enable
//   mem_rd_addr  out  RAM read address
//   mem_rd_data  in   RAM read data, valid the cycle after mem_rd
//   mem_wr       out  RAM write enable
//   mem_wr_addr  out  RAM write address
//   mem_wr_data  out  RAM write data
// -----------------------------------------------------------------------------
module qr_givens_engine #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DW       = 13,
    parameter int AW       = 5,
    parameter int ITER     = 12,
    parameter int K        = 622,
    parameter int KF       = 10,
    parameter int ZERO_RES = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_wr,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data
);

    // Two guard bits absorb the CORDIC gain (~1.65) times the sqrt(2) vector growth.
    localparam int XW    = DW + 2;
    // Number of elimination columns.
    localparam int NJ    = (ROWS - 1 < COLS) ? ROWS - 1 : COLS;
    localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
    localparam int IW    = $clog2(MAXRC + 1);
    localparam int NW    = (ITER > 1) ? $clog2(ITER) : 1;
    // Signed width for K with a clear sign bit.
    localparam int KW    = $clog2(K + 1) + 1;
    localparam int PW    = XW + KW;

    localparam logic signed [KW-1:0] K_S     = KW'(K);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DW - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_X, S_RD_Y, S_LOAD, S_CALC, S_SCALE, S_WR_X, S_WR_Y, S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_rd;
    logic [AW-1:0]         r_mem_rd_addr;
    logic                  r_mem_wr;
    logic [AW-1:0]         r_mem_wr_addr;
    logic [DW-1:0]         r_mem_wr_data;
    logic signed [XW-1:0]  r_x;
    logic signed [XW-1:0]  r_y;
    logic [ITER-1:0]       r_d;
    logic                  r_q;
    logic [NW-1:0]         r_n;
    logic [IW-1:0]         r_j;
    logic [IW-1:0]         r_i;
    logic [IW-1:0]         r_k;

    // Column-major address of element (row, col).
    function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] col,
                                              input logic [IW-1:0] row);
        return AW'(col) * AW'(ROWS) + AW'(row);
    endfunction

    // Gain compensation: floor((v*K) / 2^KF), then clamp to the DW-bit range.
    function automatic logic signed [XW-1:0] scale_sat(input logic signed [XW-1:0] v);
        logic signed [PW-1:0] p;
        p = (PW'(v) * PW'(K_S)) >>> KF;
        if (p > SAT_MAX)
            p = SAT_MAX;
        else if (p < SAT_MIN)
            p = SAT_MIN;
        return XW'(p);
    endfunction

    // Vectoring op: the current column is the elimination column.
    logic                 w_vec;
    logic                 w_dn;
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;
    logic signed [XW-1:0] w_x_rot;
    logic signed [XW-1:0] w_y_rot;
    logic signed [XW-1:0] w_rd_ext;
    logic signed [XW-1:0] w_sx;
    logic signed [XW-1:0] w_sy;
    logic                 w_neg;
    logic                 w_k_last;
    logic                 w_i_last;
    logic                 w_j_last;
    logic                 w_fin;
    logic [IW-1:0]        w_nj;
    logic [IW-1:0]        w_ni;
    logic [IW-1:0]        w_nk;

    assign w_vec    = (r_k == r_j);
    // Vectoring drives y toward zero. Rotation replays the stored directions.
    assign w_dn     = w_vec ? ~r_y[XW-1] : r_d[r_n];
    assign w_xs     = r_x >>> r_n;
    assign w_ys     = r_y >>> r_n;
    assign w_x_rot  = w_dn ? r_x + w_ys : r_x - w_ys;
    assign w_y_rot  = w_dn ? r_y - w_xs : r_y + w_xs;
    assign w_rd_ext = XW'($signed(mem_rd_data));
    assign w_sx     = scale_sat(r_x);
    assign w_sy     = scale_sat(r_y);
    // Quadrant pre-correction: a negative X is rotated by 180 degrees first.
    assign w_neg    = w_vec ? r_x[XW-1] : r_q;

    // Schedule walk: k runs across the row pair, i walks up, j moves right.
    assign w_k_last = (r_k == IW'(COLS - 1));
    assign w_i_last = (r_i == r_j + IW'(1));
    assign w_j_last = (r_j == IW'(NJ - 1));
    assign w_fin    = w_k_last && w_i_last && w_j_last;
    assign w_nk     = !w_k_last ? r_k + IW'(1) : (!w_i_last ? r_j : r_j + IW'(1));
    assign w_ni     = !w_k_last ? r_i : (!w_i_last ? r_i - IW'(1) : IW'(ROWS - 1));
    assign w_nj     = (w_k_last && w_i_last) ? r_j + IW'(1) : r_j;

    // NOTE: all state and registered outputs use non-blocking assignments, so every
    // right-hand side sees the pre-edge values. The CORDIC "old values" rule relies on this.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_rd_addr <= '0;
            r_mem_wr      <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_x           <= '0;
            r_y           <= '0;
            // NOTE: the direction bits are a small flop vector, not a RAM, so they
            // take a reset like every other register here.
            r_d           <= '0;
            r_q           <= 1'b0;
            r_n           <= '0;
            r_j           <= '0;
            r_i           <= '0;
            r_k           <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (NJ == 0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_RD_X;
                            r_busy        <= 1'b1;
                            r_mem_rd      <= 1'b1;
                            r_j           <= '0;
                            r_i           <= IW'(ROWS - 1);
                            r_k           <= '0;
                            r_mem_rd_addr <= addr_of('0, IW'(ROWS - 2));
                        end
                    end
                end
                S_RD_X: begin
                    r_state       <= S_RD_Y;
                    r_mem_rd_addr <= addr_of(r_k, r_i);
                end
                S_RD_Y: begin
                    r_state  <= S_LOAD;
                    r_mem_rd <= 1'b0;
                    r_x      <= w_rd_ext;
                end
                S_LOAD: begin
                    r_state <= S_CALC;
                    r_n     <= '0;
                    r_x     <= w_neg ? -r_x : r_x;
                    r_y     <= w_neg ? -w_rd_ext : w_rd_ext;
                    if (w_vec)
                        r_q <= r_x[XW-1];
                end
                S_CALC: begin
                    r_x <= w_x_rot;
                    r_y <= w_y_rot;
                    if (w_vec)
                        r_d[r_n] <= ~r_y[XW-1];
                    if (r_n == NW'(ITER - 1))
                        r_state <= S_SCALE;
                    else
                        r_n <= r_n + NW'(1);
                end
                S_SCALE: begin
                    r_state       <= S_WR_X;
                    r_x           <= w_sx;
                    r_y           <= w_sy;
                    r_mem_wr      <= 1'b1;
                    r_mem_wr_addr <= addr_of(r_k, r_i - IW'(1));
                    r_mem_wr_data <= w_sx[DW-1:0];
                end
                S_WR_X: begin
                    r_state       <= S_WR_Y;
                    r_mem_wr_addr <= addr_of(r_k, r_i);
                    r_mem_wr_data <= (w_vec && ZERO_RES != 0) ? '0 : r_y[DW-1:0];
                end
                S_WR_Y: begin
                    r_mem_wr <= 1'b0;
                    if (w_fin) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state       <= S_RD_X;
                        r_mem_rd      <= 1'b1;
                        r_j           <= w_nj;
                        r_i           <= w_ni;
                        r_k           <= w_nk;
                        r_mem_rd_addr <= addr_of(w_nk, w_ni - IW'(1));
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_rd      = r_mem_rd;
    assign mem_rd_addr = r_mem_rd_addr;
    assign mem_wr      = r_mem_wr;
    assign mem_wr_addr = r_mem_wr_addr;
    assign mem_wr_data = r_mem_wr_data;

endmodule

// File: tb/tb_qr_givens_engine.sv
// -----------------------------------------------------------------------------
// tb_qr_givens_engine
//
// Runs a default 4x4 engine and a 2x2 engine against behavioural RAMs. Results
// are compared with an integer Givens/CORDIC model of the matrix.
// -----------------------------------------------------------------------------
module tb_qr_givens_engine;

    localparam int DW   = 13;
    localparam int ITER = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4x4 instance
    logic          b_start, b_busy, b_done, b_rd, b_wr;
    logic [4:0]    b_rd_addr, b_wr_addr;
    logic [DW-1:0] b_rd_data, b_wr_data;
    // 2x2 instance
    logic          s_start, s_busy, s_done, s_rd, s_wr;
    logic [1:0]    s_rd_addr, s_wr_addr;
    logic [DW-1:0] s_rd_data, s_wr_data;

    qr_givens_engine u_big (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd(b_rd), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
        .mem_wr(b_wr), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data)
    );

    qr_givens_engine #(.ROWS(2), .COLS(2), .AW(2)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .mem_rd(s_rd), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
        .mem_wr(s_wr), .mem_wr_addr(s_wr_addr), .mem_wr_data(s_wr_data)
    );

    // Behavioural RAMs with a bench-side preload port.
    logic signed [DW-1:0] mem_b [0:31];
    logic signed [DW-1:0] mem_s [0:3];
    logic                 ld_b = 1'b0, ld_s = 1'b0;
    logic [4:0]           ld_addr = '0;
    logic [DW-1:0]        ld_data = '0;

    always @(posedge clk) begin
        if (ld_b)      mem_b[ld_addr] <= ld_data;
        else if (b_wr) mem_b[b_wr_addr] <= b_wr_data;
        if (b_rd)      b_rd_data <= mem_b[b_rd_addr];
        if (ld_s)      mem_s[ld_addr[1:0]] <= ld_data;
        else if (s_wr) mem_s[s_wr_addr] <= s_wr_data;
        if (s_rd)      s_rd_data <= mem_s[s_rd_addr];
    end

    // Muxed view of whichever instance is under test.
    logic cur = 1'b0;
    logic c_busy, c_done, c_rd, c_wr;
    assign c_busy = cur ? s_busy : b_busy;
    assign c_done = cur ? s_done : b_done;
    assign c_rd   = cur ? s_rd   : b_rd;
    assign c_wr   = cur ? s_wr   : b_wr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Tolerance comparison: values inside +-2 of the target count as the target.
    task automatic check_near(input string tag, input int obs, input int exp);
        int diff;
        diff = obs - exp;
        check(tag, (diff >= -2 && diff <= 2) ? exp : obs, exp);
    endtask

    // ---------------- reference model ----------------
    int gm [0:3][0:3];

    function automatic int sat_scale(input int v);
        int p;
        p = (v * 622) >>> 10;
        if (p > 4095)  p = 4095;
        if (p < -4096) p = -4096;
        return p;
    endfunction

    // One CORDIC micro-rotation on plain integers.
    task automatic micro(inout int x, inout int y, input bit d, input int n);
        int tx;
        tx = x;
        if (d) begin x = x + (y >>> n); y = y - (tx >>> n); end
        else   begin x = x - (y >>> n); y = y + (tx >>> n); end
    endtask

    task automatic model_qr(input int rows, input int cols);
        int nj, x, y;
        bit q;
        bit dv [ITER];
        nj = (rows - 1 < cols) ? rows - 1 : cols;
        for (int j = 0; j < nj; j++) begin
            for (int i = rows - 1; i > j; i--) begin
                x = gm[i-1][j]; y = gm[i][j];
                q = (x < 0);
                if (q) begin x = -x; y = -y; end
                for (int n = 0; n < ITER; n++) begin
                    dv[n] = (y >= 0);
                    micro(x, y, dv[n], n);
                end
                gm[i-1][j] = sat_scale(x);
                gm[i][j]   = 0;
                for (int k = j + 1; k < cols; k++) begin
                    x = gm[i-1][k]; y = gm[i][k];
                    if (q) begin x = -x; y = -y; end
                    for (int n = 0; n < ITER; n++) micro(x, y, dv[n], n);
                    gm[i-1][k] = sat_scale(x);
                    gm[i][k]   = sat_scale(y);
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic set_start(input bit sel, input bit v);
        if (sel) s_start = v; else b_start = v;
    endtask

    task automatic load(input bit sel, input int addr, input int val);
        ld_addr = addr[4:0];
        ld_data = val[DW-1:0];
        if (sel) ld_s = 1'b1; else ld_b = 1'b1;
        @(posedge clk); #1;
        ld_b = 1'b0; ld_s = 1'b0;
    endtask

    task automatic load_mat(input bit sel, input int rows, input int cols);
        for (int c = 0; c < cols; c++)
            for (int r = 0; r < rows; r++)
                load(sel, c * rows + r, gm[r][c]);
    endtask

    task automatic rand_fill(input int rows, input int cols, input int span);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                gm[r][c] = int'($urandom_range(0, 2 * span - 1)) - span;
    endtask

    task automatic cmp_mat(input bit sel, input int rows, input int cols, input string tag);
        int obs;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                obs = sel ? int'(mem_s[c * rows + r]) : int'(mem_b[c * rows + r]);
                check($sformatf("%s_a%0d%0d", tag, r, c), obs, gm[r][c]);
            end
    endtask

    // Start a run, measure timing and bus overlap, and optionally hold start
    // high to exercise the back-to-back restart.
    task automatic run(input bit sel, input int ops, input bit hold, input string tag);
        int n, nbusy, nov, done_at, got2;
        cur = sel; n = 0; nbusy = 0; nov = 0; done_at = -1;
        @(negedge clk); set_start(sel, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(sel, 1'b0);
        for (int c = 0; c < 2000 && done_at < 0; c++) begin
            @(negedge clk); n++;
            if (c_busy) nbusy++;
            if (c_rd && c_wr) nov++;
            if (c_done) done_at = n;
            else if (!hold) set_start(sel, c_busy && ($urandom_range(0, 7) == 0));
        end
        if (!hold) set_start(sel, 1'b0);
        check({tag, "_done_cycle"}, done_at, ops * (ITER + 6) + 1);
        check({tag, "_busy_cycles"}, nbusy, ops * (ITER + 6));
        check({tag, "_rd_wr_overlap"}, nov, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(c_done), 0);
        check({tag, "_idle_busy"}, int'(c_busy), 0);
        if (hold) begin
            @(negedge clk);
            check({tag, "_b2b_busy"}, int'(c_busy), 1);
            set_start(sel, 1'b0);
            got2 = 0;
            for (int c = 0; c < 2000 && got2 == 0; c++) begin
                @(negedge clk);
                if (c_done) got2 = 1;
            end
            check({tag, "_b2b_done"}, got2, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; b_start = 1'b0; s_start = 1'b0;
        #12;
        check("rst_busy", int'(b_busy), 0);
        check("rst_done", int'(b_done), 0);
        check("rst_rd_wr", int'(b_rd) + int'(b_wr), 0);
        check("rst_addr_data", int'(b_rd_addr) + int'(b_wr_addr) + int'(b_wr_data), 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        // 2x2 basic: 3-4-5 triangle.
        gm[0][0] = 300; gm[0][1] = 100; gm[1][0] = 400; gm[1][1] = 0;
        load_mat(1'b1, 2, 2); model_qr(2, 2);
        run(1'b1, 2, 1'b0, "basic");
        check_near("basic_a00", int'(mem_s[0]), 500);
        check("basic_a10", int'(mem_s[1]), 0);
        check_near("basic_a01", int'(mem_s[2]), 60);
        check_near("basic_a11", int'(mem_s[3]), -80);
        cmp_mat(1'b1, 2, 2, "basic");

        // Negative X exercises the quadrant flag on both op kinds.
        gm[0][0] = -300; gm[0][1] = 100; gm[1][0] = 400; gm[1][1] = 0;
        load_mat(1'b1, 2, 2); model_qr(2, 2);
        run(1'b1, 2, 1'b0, "negx");
        check_near("negx_a00", int'(mem_s[0]), 500);
        check("negx_a10", int'(mem_s[1]), 0);
        check_near("negx_a01", int'(mem_s[2]), -60);
        check_near("negx_a11", int'(mem_s[3]), -80);
        cmp_mat(1'b1, 2, 2, "negx");

        // Saturation of the scaled magnitude.
        gm[0][0] = 4095; gm[1][0] = 4095;
        gm[0][1] = int'($urandom_range(0, 1999)) - 1000;
        gm[1][1] = int'($urandom_range(0, 1999)) - 1000;
        load_mat(1'b1, 2, 2); model_qr(2, 2);
        run(1'b1, 2, 1'b0, "sat");
        check("sat_a00", int'(mem_s[0]), 4095);
        cmp_mat(1'b1, 2, 2, "sat");

        // All-zero pivot column with start held high for a back-to-back rerun.
        gm[0][0] = 0; gm[1][0] = 0; gm[0][1] = 5; gm[1][1] = 7;
        load_mat(1'b1, 2, 2); model_qr(2, 2); model_qr(2, 2);
        run(1'b1, 2, 1'b1, "zero");
        check("zero_a00", int'(mem_s[0]), 0);
        cmp_mat(1'b1, 2, 2, "zero");

        // Default 4x4, randomized, full and reduced ranges.
        rand_fill(4, 4, 4096);
        load_mat(1'b0, 4, 4); model_qr(4, 4);
        run(1'b0, 20, 1'b0, "rand_full");
        cmp_mat(1'b0, 4, 4, "rand_full");

        rand_fill(4, 4, 1000);
        load_mat(1'b0, 4, 4); model_qr(4, 4);
        run(1'b0, 20, 1'b0, "rand_small");
        cmp_mat(1'b0, 4, 4, "rand_small");

        // Reset in the middle of a 4x4 run, then a clean rerun.
        rand_fill(4, 4, 2000);
        load_mat(1'b0, 4, 4);
        cur = 1'b0;
        @(negedge clk); b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        repeat (50) @(negedge clk);
        check("midrst_busy_before", int'(b_busy), 1);
        reset = 1'b0;
        #1;
        check("midrst_busy", int'(b_busy), 0);
        check("midrst_done", int'(b_done), 0);
        check("midrst_rd_wr", int'(b_rd) + int'(b_wr), 0);
        check("midrst_addr_data", int'(b_rd_addr) + int'(b_wr_addr) + int'(b_wr_data), 0);
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        rand_fill(4, 4, 3000);
        load_mat(1'b0, 4, 4); model_qr(4, 4);
        run(1'b0, 20, 1'b0, "after_rst");
        cmp_mat(1'b0, 4, 4, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qr_givens_engine.md
Name: qr_givens_engine

Overview:
- Parametrised successor of the fixed 4x4 QR/CORDIC controller: in-place Givens QR triangularisation of a ROWS x COLS signed matrix held in one external dual-port RAM.
- One shared iterative CORDIC datapath (1 micro-rotation/clk) serves vectoring and rotation modes.
- New vs. previous generation: start/busy/done handshake, quadrant pre-correction for negative X, saturating K-scale, configurable size/iterations.
- Sits between the matrix RAM and the downstream back-substitution block.

Parameters:
ROWS, 4, matrix rows (>=1)
COLS, 4, matrix columns (>=1)
DW, 13, data width, signed two's complement
AW, 5, RAM address width; must satisfy 2^AW >= ROWS*COLS
ITER, 12, CORDIC micro-rotations per pair (1..DW+2)
K, 622, CORDIC gain compensation, unsigned Q0.KF
KF, 10, fractional bits of K
ZERO_RES, 1, 1: vectoring writes exact 0 to the eliminated element; 0: writes the computed residual

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin decomposition; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start through the last WR_Y
done  out  1  one-cycle pulse after the last write
mem_rd  out  1  RAM read enable
mem_rd_addr  out  AW  read address, col*ROWS+row
mem_rd_data  in  DW  read data, valid the cycle after mem_rd
mem_wr  out  1  RAM write enable
mem_wr_addr  out  AW  write address
mem_wr_data  out  DW  write data

Behaviour:
- Reset (async, active-low): state=IDLE; busy=done=mem_rd=mem_wr=0; addresses, write data, x/y/d registers=0. Reset mid-operation aborts immediately; no write completes; the RAM is left partially updated.
- Schedule: for j=0..min(ROWS-1,COLS)-1, for i=ROWS-1 down to j+1:
  - one vectoring op on pair (A[i-1][j], A[i][j]);
  - then rotation ops on (A[i-1][k], A[i][k]) for k=j+1..COLS-1, using the stored direction bits and quadrant flag.
  - If ROWS<=1, the block passes IDLE->DONE with no RAM access.
- States: IDLE, RD_X, RD_Y, LOAD, CALC, SCALE, WR_X, WR_Y, DONE. Each op takes ITER+6 cycles:
  - RD_X: mem_rd=1, addr=X element.
  - RD_Y: mem_rd=1, addr=Y element; x<=mem_rd_data sign-extended to DW+2 bits.
  - LOAD: y<=mem_rd_data. Vectoring: if x<0, negate both and set q=1, else q=0. Rotation: negate both iff stored q=1.
  - CALC: ITER cycles, iteration n=0..ITER-1, arithmetic shifts.
    - Vectoring: d[n]=(y>=0). If d=1: x+=y>>>n, y-=x>>>n; else x-=y>>>n, y+=x>>>n (old values on the right-hand side). Store d[n].
    - Rotation: same equations driven by stored d[n].
  - SCALE: x,y <= (v*K)>>>KF, truncating toward -inf, then saturated to [-2^(DW-1), 2^(DW-1)-1].
  - WR_X: mem_wr=1, writes x to the X address.
  - WR_Y: mem_wr=1, writes y to the Y address, or 0 in vectoring when ZERO_RES=1.
  - After WR_Y: go to RD_X of the next op, or to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- mem_rd and mem_wr are never high in the same cycle. Outputs are registered, or decoded from state only.
- start while busy is ignored. start held high in IDLE is accepted again the cycle after DONE, i.e. back-to-back runs.
- x=y=0 in vectoring: all d=1, q=0, writes 0/0; no error.
- Total cycles from start edge to the done pulse = ops*(ITER+6)+1, where ops = sum over j of (ROWS-1-j)*(COLS-j).

Test Plan:
- ROWS=2, COLS=1, A00=300, A10=400 -> A00=500±2, A10=0; done after 1*(18)+1=19 cycles; busy high for 18.
- ROWS=COLS=2, A=[[300,100],[400,0]] -> A00=500±2, A10=0, A01=60±2, A11=-80±2.
- Negative X: A00=-300, A10=400 -> A00=500±2, A10=0 (q path). Same with column-1 rotation gives A01=-60±2, A11=-80±2.
- Saturation: A00=4095, A10=4095 (DW=13) -> A00=4095, not wrapped.
- Default 4x4, random data -> RAM matches golden fixed-point model bit-exactly; lower triangle 0; 20 ops, done at cycle 361; no simultaneous mem_rd/mem_wr; start pulses during busy ignored.
- Assert reset at cycle 50 of a 4x4 run -> all outputs 0 the same cycle; a new start then completes a clean run with the expected result.
